// File: rtl/bist_pkg.sv
// Shared types and LFSR/MISR step functions for the BIST controller.
// The functions work on MAX_W-bit values; callers zero-extend their operands and cast the result back to WIDTH.
package bist_pkg;

    localparam int MAX_W = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_CHECK,
        S_DONE
    } bist_state_t;

    // Shift left by one and insert the parity of the tapped bits as the new LSB.
    function automatic logic [MAX_W-1:0] lfsr_next(input logic [MAX_W-1:0] state,
                                                   input logic [MAX_W-1:0] taps);
        return {state[MAX_W-2:0], ^(state & taps)};
    endfunction

    function automatic logic [MAX_W-1:0] misr_next(input logic [MAX_W-1:0] state,
                                                   input logic [MAX_W-1:0] taps,
                                                   input logic [MAX_W-1:0] resp);
        return lfsr_next(state, taps) ^ resp;
    endfunction

endpackage

// File: rtl/lfsr_gen.sv
// Fibonacci-style pattern LFSR with a synchronous load and a step enable.
// Load takes priority over enable.
module lfsr_gen
    import bist_pkg::*;
#(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] TAPS      = 4'b1100,
    parameter logic [WIDTH-1:0] RESET_VAL = 4'h1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic [WIDTH-1:0] state
);

    logic [WIDTH-1:0] state_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RESET_VAL;
        end else if (load) begin
            state_q <= load_val;
        end else if (en) begin
            state_q <= WIDTH'(lfsr_next(MAX_W'(state_q), MAX_W'(TAPS)));
        end
    end

    assign state = state_q;

endmodule

// File: rtl/lfsr_bist_ctrl.sv
// BIST controller: seeds the pattern LFSR, applies NUM_PATTERNS patterns to a combinational CUT,
// compacts the responses in a MISR and compares the final signature against GOLDEN.
module lfsr_bist_ctrl
    import bist_pkg::*;
#(
    parameter int               WIDTH        = 4,
    parameter logic [WIDTH-1:0] TAPS         = 4'b1100,
    parameter logic [WIDTH-1:0] SEED         = 4'h1,
    parameter int               NUM_PATTERNS = 15,
    parameter logic [WIDTH-1:0] GOLDEN       = 4'h0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             ext_seed_en,
    input  logic [WIDTH-1:0] seed_in,
    input  logic [WIDTH-1:0] cut_resp,
    output logic [WIDTH-1:0] pattern,
    output logic             pattern_valid,
    output logic [WIDTH-1:0] signature,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output bist_state_t      state
);

    localparam int CW = $clog2(NUM_PATTERNS + 1);

    bist_state_t      state_q, state_d;
    logic             ext_sel_q;
    logic [WIDTH-1:0] misr_q;
    logic [WIDTH-1:0] misr_nx;
    logic [CW-1:0]    cnt_q;
    logic             pass_q;
    logic [WIDTH-1:0] lfsr;
    logic [WIDTH-1:0] seed_pick;
    logic [WIDTH-1:0] load_val;
    logic             lfsr_load;
    logic             lfsr_en;
    logic             last;

    // An all-zero seed would lock the LFSR, so it falls back to SEED.
    assign seed_pick = ext_sel_q ? seed_in : SEED;
    assign load_val  = (seed_pick == '0) ? SEED : seed_pick;
    assign last      = (cnt_q == CW'(NUM_PATTERNS - 1));
    assign misr_nx   = WIDTH'(misr_next(MAX_W'(misr_q), MAX_W'(TAPS), MAX_W'(cut_resp)));

    lfsr_gen #(
        .WIDTH    (WIDTH),
        .TAPS     (TAPS),
        .RESET_VAL(SEED)
    ) u_gen (
        .clk     (clk),
        .reset   (reset),
        .load    (lfsr_load),
        .load_val(load_val),
        .en      (lfsr_en),
        .state   (lfsr)
    );

    always_comb begin
        state_d   = state_q;
        lfsr_load = 1'b0;
        lfsr_en   = 1'b0;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_LOAD;
            S_LOAD: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    lfsr_load = 1'b1;
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                // Abort outranks the final step, leaving LFSR/MISR at their partial values.
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    lfsr_en = 1'b1;
                    if (last) state_d = S_CHECK;
                end
            end
            S_CHECK: state_d = S_DONE;
            S_DONE:  if (start) state_d = S_LOAD;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ext_sel_q <= 1'b0;
            misr_q    <= '0;
            cnt_q     <= '0;
            pass_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if ((state_q == S_IDLE || state_q == S_DONE) && start) begin
                ext_sel_q <= ext_seed_en;
            end
            case (state_q)
                S_LOAD: begin
                    pass_q <= 1'b0;
                    if (!abort) begin
                        misr_q <= '0;
                        cnt_q  <= '0;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        pass_q <= 1'b0;
                    end else begin
                        misr_q <= misr_nx;
                        cnt_q  <= cnt_q + CW'(1);
                    end
                end
                S_CHECK: pass_q <= (misr_q == GOLDEN);
                default: ;
            endcase
        end
    end

    // pattern_valid qualifies pattern for exactly one cycle per pattern; there is no ready, the CUT
    // is combinational and cut_resp is sampled at the edge that ends every valid cycle.
    assign pattern       = lfsr;
    assign pattern_valid = (state_q == S_RUN);
    assign signature     = misr_q;
    assign busy          = (state_q == S_LOAD) || (state_q == S_RUN) || (state_q == S_CHECK);
    assign done          = (state_q == S_DONE);
    assign pass          = pass_q;
    assign state         = state_q;

endmodule

// File: doc/lfsr_bist_ctrl.md
# lfsr_bist_ctrl

Built-in self-test controller for an LFSR pattern generator. On `start` it seeds the LFSR and applies a fixed number of patterns to a combinational circuit-under-test (CUT). It compacts the CUT responses in a MISR and compares the final signature with a golden value. It sits between the test-access logic (start/abort, pass/done) and the CUT inputs and outputs.

## Interface
- `WIDTH`, 4: LFSR, MISR and CUT width (≥2).
- `TAPS`, 4'b1100: feedback tap mask. Feedback bit is `^(state & TAPS)`. The default gives `q[3]^q[2]`.
- `SEED`, 4'h1: default non-zero seed.
- `NUM_PATTERNS`, 15: patterns applied per run (1..2^WIDTH-1).
- `GOLDEN`, 4'h0: expected MISR signature.

Ports:
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: level sampled in IDLE or DONE; begins a run.
- `abort` in 1: cancels a run in LOAD or RUN.
- `ext_seed_en` in 1: sampled with `start`; selects `seed_in` over `SEED`.
- `seed_in` in WIDTH: external seed.
- `cut_resp` in WIDTH: CUT response to the current `pattern`.
- `pattern` out WIDTH: LFSR state driven to the CUT.
- `pattern_valid` out 1: high in RUN only.
- `signature` out WIDTH: MISR contents.
- `busy` out 1: high in LOAD, RUN and CHECK.
- `done` out 1: high in DONE.
- `pass` out 1: registered compare result. Valid while `done`=1.

## Operation
- **FSM states:** IDLE, LOAD, RUN, CHECK, DONE. All registered.
- **IDLE:** if `start`=1, capture the seed select and go to LOAD.
- **LOAD:** one cycle.
  - `lfsr <= ext_sel ? seed_in : SEED`. If the chosen seed is 0, substitute `SEED` (lock-up avoidance).
  - `misr <= 0`, `cnt <= 0`, `pass <= 0`.
  - Go to RUN.
- **RUN:** one pattern per cycle.
  - `pattern = lfsr`, `pattern_valid` = 1.
  - At the clock edge:
    - `lfsr <= {lfsr[W-2:0], ^(lfsr&TAPS)}`
    - `misr <= {misr[W-2:0], ^(misr&TAPS)} ^ cut_resp`
    - `cnt <= cnt+1`
  - When `cnt == NUM_PATTERNS-1`, the update is the last one; go to CHECK.
- **CHECK:** one cycle. `pass <= (misr == GOLDEN)`. Go to DONE.
- **DONE:** `done`=1, `pass` and `signature` held.
  - `start`=1 goes to LOAD (re-run, with a new seed select).
  - Otherwise stay in DONE.
- **Abort:** `abort`=1 in LOAD or RUN goes to IDLE. `pass` is cleared, `done` is not asserted, and the LFSR/MISR keep their partial values. Abort wins over the RUN→CHECK transition in the same cycle. `abort` is ignored in IDLE, CHECK and DONE.
- **Counter:** `cnt` is `$clog2(NUM_PATTERNS+1)` bits. It never wraps within a run.
- **Pattern sequence:** with default parameters the sequence is 1,2,4,9,3,6,D,A,5,B,7,F,E,C,8 (period 15, no repeat within a run).

## Timing
- **Reset values:** state=IDLE, `lfsr`=`SEED`, `misr`=0, `cnt`=0, `pattern`=`SEED`, `pattern_valid`=0, `signature`=0, `busy`=0, `done`=0, `pass`=0.
- **Run latency:** `start` sampled at edge 0 → LOAD in cycle 1 → RUN in cycles 2..N+1 → CHECK in cycle N+2 → `done`/`pass` visible from cycle N+3. Total N+3 cycles.
- **CUT timing:** `cut_resp` must settle within the same cycle as `pattern` (combinational CUT). It is sampled at the edge that ends each RUN cycle.
- **Reset mid-run:** asynchronous return to reset values immediately. No partial `done`.
- **Restart from DONE:** `start` held high in DONE re-runs continuously, with one DONE cycle between runs.

## Structure
- **Shared package `bist_pkg`:**
  - state enum `bist_state_t`;
  - `lfsr_next(state, taps)` function;
  - `misr_next(state, taps, resp)` function.
- **Sub-module `lfsr_gen`** (WIDTH, TAPS): load and enable inputs, state output. Instantiated for the pattern generator. The MISR uses `misr_next` inline.
- **Controller:** FSM and counter in `lfsr_bist_ctrl`.

## Test plan
- **Reset during RUN:** assert `reset` at cycle 5 → all outputs return to reset values asynchronously, before the next edge.
- **Default pattern sequence:** defaults, `cut_resp`=0, `start` pulse → `pattern` 1,2,4,9,3,6,D,A,5,B,7,F,E,C,8 with `pattern_valid` for exactly 15 cycles. `signature`=0, `pass`=1, `done` at cycle 18.
- **Loopback signature:** `NUM_PATTERNS`=3, `cut_resp`=`pattern`, `GOLDEN`=4'h4 → `signature`=4'h4, `pass`=1. Repeat with `GOLDEN`=4'h5 → `pass`=0.
- **External seed:** `ext_seed_en`=1 with `seed_in`=4'hB → first pattern B, then 7, F. With `seed_in`=0 → first pattern 1.
- **Abort:** `abort` asserted in the 4th RUN cycle → IDLE next cycle, `done`=0, `pass`=0, `pattern_valid`=0. A following `start` completes a full run normally.
- **Restart:** `start` held high through DONE → second run produces an identical pattern sequence and signature.
